// File: rtl/bit_stream_sched_if.sv
// Handshake/data bundle between a word source and the bit-stream scheduler.
// start is a request sampled only while busy=0; busy=1 means the word is owned by the scheduler.
interface bit_stream_sched_if;
  logic       start;
  logic [7:0] data;
  logic       busy;
  logic       bit_out;
  logic       bit_valid;
  logic       match;
  logic [3:0] match_cnt;
  logic       done;
  logic [1:0] dbg_ctrl;
  logic [1:0] dbg_det;

  modport slave (
    input  start,
    input  data,
    output busy,
    output bit_out,
    output bit_valid,
    output match,
    output match_cnt,
    output done,
    output dbg_ctrl,
    output dbg_det
  );

  modport master (
    output start,
    output data,
    input  busy,
    input  bit_out,
    input  bit_valid,
    input  match,
    input  match_cnt,
    input  done,
    input  dbg_ctrl,
    input  dbg_det
  );
endinterface

// File: rtl/bit_stream_sched.sv
// Serializes an 8-bit word LSB first, one bit every DIV clocks, and counts 1011 patterns.
// Define DETECT_CARRY_EN to keep detector state across words.
module bit_stream_sched #(
  parameter int unsigned DIV = 4
) (
  input  logic               clk,
  input  logic               set,
  bit_stream_sched_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, FIN = 2'd2} ctrl_e;
  typedef enum logic [1:0] {S0 = 2'd0, S1 = 2'd1, S2 = 2'd2, S3 = 2'd3} det_e;

  localparam logic [7:0] STEP_RELOAD = 8'(DIV - 1);

  ctrl_e      state_q;
  det_e       det_q, det_d;
  logic       hit_d;
  logic [7:0] sh_q;
  logic [7:0] step_q;
  logic [2:0] idx_q;
  logic       last_q;
  logic       busy_q, bit_out_q, bit_valid_q, match_q, done_q;
  logic [3:0] cnt_q;

  // Mealy detector step for the bit about to leave the shift register.
  always_comb begin
    det_d = det_q;
    hit_d = 1'b0;
    case (det_q)
      S0: det_d = sh_q[0] ? S1 : S0;
      S1: det_d = sh_q[0] ? S1 : S2;
      S2: det_d = sh_q[0] ? S3 : S0;
      S3: begin
        det_d = sh_q[0] ? S1 : S2;
        hit_d = sh_q[0];
      end
      default: det_d = S0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (set) begin
      state_q     <= IDLE;
      det_q       <= S0;
      sh_q        <= '0;
      step_q      <= '0;
      idx_q       <= '0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      match_q     <= 1'b0;
      done_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      bit_valid_q <= 1'b0;
      match_q     <= 1'b0;
      done_q      <= 1'b0;
      if (match_q && cnt_q != 4'd15) begin
        cnt_q <= cnt_q + 4'd1;
      end
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            sh_q    <= bus.data;
            cnt_q   <= '0;
            step_q  <= STEP_RELOAD;
            idx_q   <= '0;
            last_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
`ifdef DETECT_CARRY_EN
            det_q   <= det_q;
`else
            det_q   <= S0;
`endif
          end
        end
        SHIFT: begin
          // The cycle after the eighth strobe closes the word.
          if (last_q) begin
            state_q <= FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (step_q == 8'd0) begin
            bit_out_q   <= sh_q[0];
            bit_valid_q <= 1'b1;
            sh_q        <= {1'b0, sh_q[7:1]};
            det_q       <= det_d;
            match_q     <= hit_d;
            step_q      <= STEP_RELOAD;
            idx_q       <= idx_q + 3'd1;
            if (idx_q == 3'd7) begin
              last_q <= 1'b1;
            end
          end else begin
            step_q <= step_q - 8'd1;
          end
        end
        FIN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.bit_out   = bit_out_q;
  assign bus.bit_valid = bit_valid_q;
  assign bus.match     = match_q;
  assign bus.match_cnt = cnt_q;
  assign bus.done      = done_q;
  assign bus.dbg_ctrl  = state_q;
  assign bus.dbg_det   = det_q;

endmodule

// File: tb/tb_bit_stream_sched.sv
// Directed bench for bit_stream_sched: DIV=4 main instance plus a DIV=1 instance.
module tb_bit_stream_sched;

  logic clk;
  logic set;
  int   errors = 0;
  int   checks = 0;

  bit_stream_sched_if if0 ();
  bit_stream_sched_if if1 ();

  bit_stream_sched #(.DIV(4)) u_dut (
    .clk (clk),
    .set (set),
    .bus (if0)
  );

  bit_stream_sched #(.DIV(1)) u_dut1 (
    .clk (clk),
    .set (set),
    .bus (if1)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic do_reset();
    @(negedge clk);
    set = 1'b1;
    if0.start = 1'b0;
    if1.start = 1'b0;
    repeat (2) @(posedge clk);
    #1 set = 1'b0;
  endtask

  // Sample j is taken at the negedge after acceptance edge + j.
  task automatic run_word(input logic [7:0] d, input int inj_j, input bit fin_start,
                          output logic [7:0] bits, output logic [7:0] mset, output int nb,
                          output int first_j, output int done_j, output logic [3:0] cnt,
                          output logic busy0, output logic busy_done, output int stray);
    int guard;
    guard = 0;
    @(negedge clk);
    while ((if0.busy || if0.done) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if0.start = 1'b1;
    if0.data  = d;
    @(posedge clk);
    #1 if0.start = 1'b0;
    bits = '0; mset = '0; nb = 0; first_j = -1; done_j = -1;
    cnt = '0; busy0 = 1'b0; busy_done = 1'b1; stray = 0;
    for (int j = 0; j < 400; j++) begin
      @(negedge clk);
      if (j == 0) busy0 = if0.busy;
      if0.start = (j == inj_j);
      if (j == inj_j) if0.data = 8'h00;
      if (if0.match && !if0.bit_valid) stray++;
      if (if0.bit_valid) begin
        if (nb < 8) begin
          bits[3'(nb)] = if0.bit_out;
          mset[3'(nb)] = if0.match;
        end
        if (first_j < 0) first_j = j;
        nb++;
      end
      if (if0.done) begin
        done_j    = j;
        cnt       = if0.match_cnt;
        busy_done = if0.busy;
        if (fin_start) begin
          if0.start = 1'b1;
          if0.data  = 8'h00;
          @(posedge clk);
          #1 if0.start = 1'b0;
        end
        break;
      end
    end
    if0.start = 1'b0;
  endtask

  task automatic test_reset();
    bit seen;
    do_reset();
    @(negedge clk);
    checks++;
    if ({if0.busy, if0.bit_out, if0.bit_valid, if0.match, if0.match_cnt, if0.done} !== 9'd0) begin
      errors++; $display("FAIL reset_outputs got=%0h exp=0",
        {if0.busy, if0.bit_out, if0.bit_valid, if0.match, if0.match_cnt, if0.done});
    end
    checks++;
    if (if0.dbg_ctrl !== 2'd0 || if0.dbg_det !== 2'd0) begin
      errors++; $display("FAIL reset_states got=%0d/%0d exp=0/0", if0.dbg_ctrl, if0.dbg_det);
    end
    set = 1'b1; if0.start = 1'b1; if0.data = 8'h2D;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (if0.busy !== 1'b0) begin
      errors++; $display("FAIL reset_priority busy got=%b exp=0", if0.busy);
    end
    @(posedge clk);
    #1 set = 1'b0;
    @(posedge clk);
    #1 if0.start = 1'b0;
    @(negedge clk);
    checks++;
    if (if0.busy !== 1'b1) begin
      errors++; $display("FAIL first_start_after_reset busy got=%b exp=1", if0.busy);
    end
    seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (if0.done) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (seen !== 1'b1) begin
      errors++; $display("FAIL reset_word_done got=%b exp=1", seen);
    end
  endtask

  task automatic test_single_2d();
    logic [7:0] bits, mset; int nb, fj, dj, st; logic [3:0] cnt; logic b0, bd;
    do_reset();
    run_word(8'h2D, -1, 1'b0, bits, mset, nb, fj, dj, cnt, b0, bd, st);
    checks++; if (bits !== 8'h2D) begin errors++; $display("FAIL 2d_bits got=%h exp=2d", bits); end
    checks++; if (mset !== 8'h08) begin errors++; $display("FAIL 2d_match_pos got=%h exp=08", mset); end
    checks++; if (nb !== 8) begin errors++; $display("FAIL 2d_nbits got=%0d exp=8", nb); end
    checks++; if (fj !== 4) begin errors++; $display("FAIL 2d_first_valid got=%0d exp=4", fj); end
    checks++; if (dj !== 33) begin errors++; $display("FAIL 2d_done_lat got=%0d exp=33", dj); end
    checks++; if (cnt !== 4'd1) begin errors++; $display("FAIL 2d_match_cnt got=%0d exp=1", cnt); end
    checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL 2d_busy_after_accept got=%b exp=1", b0); end
    checks++; if (bd !== 1'b0) begin errors++; $display("FAIL 2d_busy_at_done got=%b exp=0", bd); end
    checks++; if (st !== 0) begin errors++; $display("FAIL 2d_stray_match got=%0d exp=0", st); end
  endtask

  task automatic test_overlap_6d();
    logic [7:0] bits, mset; int nb, fj, dj, st; logic [3:0] cnt; logic b0, bd;
    do_reset();
    run_word(8'h6D, -1, 1'b0, bits, mset, nb, fj, dj, cnt, b0, bd, st);
    checks++; if (bits !== 8'h6D) begin errors++; $display("FAIL 6d_bits got=%h exp=6d", bits); end
    checks++; if (mset !== 8'h48) begin errors++; $display("FAIL 6d_match_pos got=%h exp=48", mset); end
    checks++; if (cnt !== 4'd2) begin errors++; $display("FAIL 6d_match_cnt got=%0d exp=2", cnt); end
  endtask

  task automatic test_busy_ignore();
    logic [7:0] bits, mset; int nb, fj, dj, st; logic [3:0] cnt; logic b0, bd;
    do_reset();
    run_word(8'hDD, 10, 1'b1, bits, mset, nb, fj, dj, cnt, b0, bd, st);
    checks++; if (bits !== 8'hDD) begin errors++; $display("FAIL dd_bits got=%h exp=dd", bits); end
    checks++; if (mset !== 8'h88) begin errors++; $display("FAIL dd_match_pos got=%h exp=88", mset); end
    checks++; if (cnt !== 4'd2) begin errors++; $display("FAIL dd_match_cnt got=%0d exp=2", cnt); end
    checks++; if (dj !== 33) begin errors++; $display("FAIL dd_done_lat got=%0d exp=33", dj); end
    @(negedge clk);
    checks++;
    if (if0.busy !== 1'b0 || if0.dbg_ctrl !== 2'd0) begin
      errors++; $display("FAIL fin_start_ignored busy=%b state=%0d exp busy=0 state=0", if0.busy, if0.dbg_ctrl);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (if0.match_cnt !== 4'd2 || if0.busy !== 1'b0) begin
      errors++; $display("FAIL cnt_hold got=%0d busy=%b exp=2 busy=0", if0.match_cnt, if0.busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bits, mset; int nb, fj, dj, st; logic [3:0] cnt; logic b0, bd;
    logic [7:0] exp_m; logic [3:0] exp_c;
    do_reset();
    run_word(8'hA0, -1, 1'b0, bits, mset, nb, fj, dj, cnt, b0, bd, st);
    checks++; if (cnt !== 4'd0) begin errors++; $display("FAIL a0_match_cnt got=%0d exp=0", cnt); end
    run_word(8'h01, -1, 1'b0, bits, mset, nb, fj, dj, cnt, b0, bd, st);
`ifdef DETECT_CARRY_EN
    exp_m = 8'h01; exp_c = 4'd1;
`else
    exp_m = 8'h00; exp_c = 4'd0;
`endif
    checks++; if (bits !== 8'h01) begin errors++; $display("FAIL w2_bits got=%h exp=01", bits); end
    checks++; if (mset !== exp_m) begin errors++; $display("FAIL w2_match_pos got=%h exp=%h", mset, exp_m); end
    checks++; if (cnt !== exp_c) begin errors++; $display("FAIL w2_match_cnt got=%0d exp=%0d", cnt, exp_c); end
  endtask

  task automatic test_reset_midword();
    logic [7:0] bits, mset; int nb, fj, dj, st; logic [3:0] cnt; logic b0, bd;
    int nv;
    bit hit5;
    do_reset();
    @(negedge clk);
    if0.start = 1'b1; if0.data = 8'hDD;
    @(posedge clk);
    #1 if0.start = 1'b0;
    nv = 0; hit5 = 1'b0;
    for (int j = 0; j < 100; j++) begin
      @(negedge clk);
      if (if0.bit_valid) nv++;
      if (nv == 5) begin hit5 = 1'b1; break; end
    end
    checks++; if (hit5 !== 1'b1) begin errors++; $display("FAIL midword_5th_bit got=%b exp=1", hit5); end
    set = 1'b1;
    @(posedge clk);
    #1 set = 1'b0;
    @(negedge clk);
    checks++;
    if ({if0.busy, if0.bit_out, if0.bit_valid, if0.match, if0.match_cnt, if0.done} !== 9'd0) begin
      errors++; $display("FAIL midword_reset_outputs got=%0h exp=0",
        {if0.busy, if0.bit_out, if0.bit_valid, if0.match, if0.match_cnt, if0.done});
    end
    checks++;
    if (if0.dbg_ctrl !== 2'd0 || if0.dbg_det !== 2'd0) begin
      errors++; $display("FAIL midword_reset_states got=%0d/%0d exp=0/0", if0.dbg_ctrl, if0.dbg_det);
    end
    run_word(8'h2D, -1, 1'b0, bits, mset, nb, fj, dj, cnt, b0, bd, st);
    checks++; if (cnt !== 4'd1) begin errors++; $display("FAIL post_reset_match_cnt got=%0d exp=1", cnt); end
    checks++; if (mset !== 8'h08) begin errors++; $display("FAIL post_reset_match_pos got=%h exp=08", mset); end
  endtask

  task automatic test_div1();
    logic [15:0] vj;
    logic [7:0]  bits;
    int nb, dj;
    logic [3:0] cnt;
    do_reset();
    @(negedge clk);
    if1.start = 1'b1; if1.data = 8'h2D;
    @(posedge clk);
    #1 if1.start = 1'b0;
    vj = '0; bits = '0; nb = 0; dj = -1; cnt = '0;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      vj[j] = if1.bit_valid;
      if (if1.bit_valid) begin
        if (nb < 8) bits[3'(nb)] = if1.bit_out;
        nb++;
      end
      if (if1.done && dj < 0) begin dj = j; cnt = if1.match_cnt; end
    end
    checks++; if (vj !== 16'h01FE) begin errors++; $display("FAIL div1_valid_cycles got=%h exp=01fe", vj); end
    checks++; if (bits !== 8'h2D) begin errors++; $display("FAIL div1_bits got=%h exp=2d", bits); end
    checks++; if (dj !== 9) begin errors++; $display("FAIL div1_done_lat got=%0d exp=9", dj); end
    checks++; if (cnt !== 4'd1) begin errors++; $display("FAIL div1_match_cnt got=%0d exp=1", cnt); end
  endtask

  initial begin
    set = 1'b1;
    if0.start = 1'b0; if0.data = 8'h00;
    if1.start = 1'b0; if1.data = 8'h00;
    test_reset();
    test_single_2d();
    test_overlap_6d();
    test_busy_ignore();
    test_back_to_back();
    test_reset_midword();
    test_div1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bit_stream_sched.md
BIT_STREAM_SCHED -- requirements
Module: bit_stream_sched

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter DIV, default 4: clk cycles per serialized bit; legal range 1..255.
Ports (name, direction, width, meaning):
REQ-002 The block SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port set, input, 1: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1: request to load and serialize data; sampled only while busy=0.
REQ-005 The block SHALL have port data, input, 8: word to scan; captured on the accepted start cycle.
REQ-006 The block SHALL have port busy, output, 1: high from the cycle after start acceptance until the done cycle.
REQ-007 The block SHALL have port bit_out, output, 1: current serialized bit, LSB first; valid only while bit_valid=1.
REQ-008 The block SHALL have port bit_valid, output, 1: one-cycle strobe per serialized bit.
REQ-009 The block SHALL have port match, output, 1: one-cycle pulse when the bit on bit_out completes the pattern 1011 (oldest bit first).
REQ-010 The block SHALL have port match_cnt, output, 4: saturating count of matches in the current word.
REQ-011 The block SHALL have port done, output, 1: one-cycle pulse after the 8th bit of a word.

Function
REQ-012 The block SHALL implement control FSM states IDLE, SHIFT and FIN.
REQ-013 In IDLE, start=1 SHALL capture data into an 8-bit shift register, clear match_cnt, load the step counter and enter SHIFT next cycle with busy=1.
REQ-014 In SHIFT, a step counter SHALL fire every DIV cycles; the first bit_valid SHALL occur DIV cycles after the start acceptance edge.
REQ-015 On each step, bit_out SHALL equal shift register bit 0, bit_valid SHALL be 1 for exactly one cycle, and the shift register SHALL shift right by one.
REQ-016 The detector SHALL be a 4-state Mealy FSM S0..S3 with overlap: S0 -1->S1, S0 -0->S0; S1 -1->S1, S1 -0->S2; S2 -1->S3, S2 -0->S0; S3 -1->S1 plus match, S3 -0->S2.
REQ-017 The detector SHALL advance only on bit_valid cycles, and match SHALL be registered and coincident with the bit_valid of the completing bit.
REQ-018 match_cnt SHALL increment one cycle after each match and saturate at 15.
REQ-019 After the 8th bit_valid, the FSM SHALL enter FIN: done=1 and busy=0 for one cycle, then IDLE; match_cnt SHALL hold until the next accepted start.
REQ-020 start during busy=1 SHALL be ignored with no state change; start in the FIN cycle SHALL also be ignored.
REQ-021 DIV=1 SHALL produce bit_valid on 8 consecutive cycles.

Reset
REQ-022 set=1 at a clock edge SHALL force IDLE, detector S0, shift register 0, step counter 0, and busy, bit_out, bit_valid, match, match_cnt and done all to 0, including mid-word, and SHALL take priority over start.
REQ-023 After set deasserts, the first start SHALL be accepted on the first cycle with set=0.

Configuration
REQ-024 Macro DETECT_CARRY_EN defined: detector state SHALL persist across words, so a pattern spanning two words is detected.
REQ-025 Macro DETECT_CARRY_EN undefined: detector SHALL return to S0 on every accepted start, so only in-word patterns are detected.

Verification
REQ-026 With DIV=4, data=8'h2D, start pulse: bit_out sequence 1,0,1,1,0,1,0,0; match on the 4th bit_valid only; match_cnt=1; done 33 cycles after acceptance.
REQ-027 With data=8'h6D: overlapping matches on bits 4 and 7; match_cnt=2.
REQ-028 With data=8'hA0 then data=8'h01 back-to-back: DETECT_CARRY_EN defined gives match on the first bit of word 2 and match_cnt=1; undefined gives match_cnt=0.
REQ-029 With data=8'hDD, a start during busy with data=8'h00 is ignored and the scan yields match_cnt=2; a start in the FIN cycle is ignored.
REQ-030 With set=1 asserted on the 5th bit of 8'hDD: all outputs are 0 next cycle; a new start with 8'h2D then yields match_cnt=1.
